// File: rtl/div_pkg.sv
// Shared types and arithmetic helpers for the divider sign-handling stage.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } div_state_t;

  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_DIV_ZERO,
    SPC_OVERFLOW,
    SPC_SMALL
  } div_special_t;

  // Widest operand the helpers handle; callers size-cast in and out of this width.
  localparam int unsigned DIV_MAX_WIDTH = 128;

  function automatic logic [DIV_MAX_WIDTH-1:0] div_negate(
    input logic [DIV_MAX_WIDTH-1:0] value,
    input int unsigned              width
  );
    logic [DIV_MAX_WIDTH-1:0] mask;
    mask = (width >= DIV_MAX_WIDTH) ? '1 :
           ((DIV_MAX_WIDTH'(1) << width) - DIV_MAX_WIDTH'(1));
    return (~value + DIV_MAX_WIDTH'(1)) & mask;
  endfunction

  function automatic logic [DIV_MAX_WIDTH-1:0] div_abs(
    input logic [DIV_MAX_WIDTH-1:0] value,
    input logic                     is_negative,
    input int unsigned              width
  );
    return is_negative ? div_negate(value, width) : value;
  endfunction

endpackage

// File: rtl/div_operand_conditioner.sv
// Combinational operand front end: magnitudes, result sign flags and the
// locally-resolved special cases that never reach the divider core.
module div_operand_conditioner
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] mag_a,
  output logic [DATA_WIDTH-1:0] mag_b,
  output logic                  neg_q,
  output logic                  neg_r,
  output logic                  quot_op,
  output logic                  fast_path,
  output logic [DATA_WIDTH-1:0] fast_result,
  output logic                  div_by_zero
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_op_t      op_e;
  div_special_t special_kind;
  logic         is_signed;
  logic         a_neg;
  logic         b_neg;

  assign op_e      = div_op_t'(op);
  assign is_signed = (op_e == OP_DIV) || (op_e == OP_REM);
  assign quot_op   = (op_e == OP_DIV) || (op_e == OP_DIVU);
  assign a_neg     = is_signed & dividend[DATA_WIDTH-1];
  assign b_neg     = is_signed & divisor[DATA_WIDTH-1];
  assign neg_q     = a_neg ^ b_neg;
  assign neg_r     = a_neg;

  // |most-negative| wraps back to 0x80..0, which is exactly the unsigned magnitude.
  assign mag_a = DATA_WIDTH'(div_abs(DIV_MAX_WIDTH'(dividend), a_neg, DATA_WIDTH));
  assign mag_b = DATA_WIDTH'(div_abs(DIV_MAX_WIDTH'(divisor), b_neg, DATA_WIDTH));

  always_comb begin
    special_kind = SPC_NONE;
    fast_result  = '0;
    div_by_zero  = 1'b0;
    if (divisor == '0) begin
      special_kind = SPC_DIV_ZERO;
      div_by_zero  = 1'b1;
      fast_result  = quot_op ? '1 : dividend;
    end else if (is_signed && (dividend == MOST_NEG) && (divisor == '1)) begin
      special_kind = SPC_OVERFLOW;
      fast_result  = quot_op ? dividend : '0;
    end else if (mag_a < mag_b) begin
      special_kind = SPC_SMALL;
      fast_result  = quot_op ? '0 : dividend;
    end
  end

  assign fast_path = (special_kind != SPC_NONE);

endmodule

// File: rtl/div_sign_handler.sv
// Sign pre/post-processing around the unsigned divider core for DIV/DIVU/REM/REMU,
// including locally-resolved special cases and flush handling.
module div_sign_handler
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_en_i,
  input  logic                  valid_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  valid_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] core_dividend_o,
  output logic [DATA_WIDTH-1:0] core_divisor_o,
  output logic                  core_valid_o,
  input  logic [DATA_WIDTH-1:0] core_quotient_i,
  input  logic [DATA_WIDTH-1:0] core_remainder_i,
  input  logic                  core_valid_i
);

  div_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mag_a_q, mag_b_q, result_q;
  logic                  neg_q_q, neg_r_q, quot_op_q, dbz_q;

  logic [DATA_WIDTH-1:0] c_mag_a, c_mag_b, c_fast_result;
  logic                  c_neg_q, c_neg_r, c_quot_op, c_fast_path, c_div_by_zero;

  logic                  accept;
  logic [DATA_WIDTH-1:0] core_sel;
  logic [DATA_WIDTH-1:0] core_fixed;

  div_operand_conditioner #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_conditioner (
    .op          (op_i),
    .dividend    (dividend_i),
    .divisor     (divisor_i),
    .mag_a       (c_mag_a),
    .mag_b       (c_mag_b),
    .neg_q       (c_neg_q),
    .neg_r       (c_neg_r),
    .quot_op     (c_quot_op),
    .fast_path   (c_fast_path),
    .fast_result (c_fast_result),
    .div_by_zero (c_div_by_zero)
  );

  assign accept     = valid_i && (state_q == ST_IDLE);
  assign core_sel   = quot_op_q ? core_quotient_i : core_remainder_i;
  assign core_fixed = (quot_op_q ? neg_q_q : neg_r_q)
                    ? DATA_WIDTH'(div_negate(DIV_MAX_WIDTH'(core_sel), DATA_WIDTH))
                    : core_sel;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = c_fast_path ? ST_DONE : ST_LAUNCH;
      ST_LAUNCH: state_d = flush_i ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        // A flush racing the core's done strobe has nothing left to drain.
        if (flush_i)           state_d = core_valid_i ? ST_IDLE : ST_DRAIN;
        else if (core_valid_i) state_d = ST_DONE;
      end
      ST_DRAIN:  if (core_valid_i) state_d = ST_IDLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      result_q  <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      quot_op_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else if (clk_en_i) begin
      if (accept) begin
        neg_q_q   <= c_neg_q;
        neg_r_q   <= c_neg_r;
        quot_op_q <= c_quot_op;
        dbz_q     <= c_div_by_zero;
        if (c_fast_path) begin
          result_q <= c_fast_result;
        end else begin
          mag_a_q <= c_mag_a;
          mag_b_q <= c_mag_b;
        end
      end else if ((state_q == ST_WAIT) && core_valid_i && !flush_i) begin
        result_q <= core_fixed;
      end
    end
  end

  assign ready_o         = (state_q == ST_IDLE);
  assign valid_o         = (state_q == ST_DONE) && !flush_i;
  assign core_valid_o    = (state_q == ST_LAUNCH);
  assign core_dividend_o = mag_a_q;
  assign core_divisor_o  = mag_b_q;
  assign result_o        = result_q;
  assign div_by_zero_o   = dbz_q;

endmodule

// File: doc/div_sign_handler.md
Name: div_sign_handler

Overview:
Pre/post-processing stage wrapped around the unsigned integer divider core in the execution unit. It accepts RISC-V M-extension DIV/DIVU/REM/REMU requests and converts signed operands to magnitudes. It launches the core, then sign-corrects the core result. Divide-by-zero, signed overflow and |dividend| < |divisor| are resolved locally and the core is not launched for them.

Parameters:
DATA_WIDTH, 32, operand/result width; must be a power of 2 and match the core's DATA_WIDTH.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
clk_en_i  in  1  clock enable; all registers hold when low (reset still acts)
valid_i  in  1  request strobe; accepted when valid_i && ready_o
op_i  in  2  div_op_t: DIV=0, DIVU=1, REM=2, REMU=3
dividend_i  in  DATA_WIDTH  rs1
divisor_i  in  DATA_WIDTH  rs2
flush_i  in  1  abort the in-flight request
ready_o  out  1  high only in IDLE
result_o  out  DATA_WIDTH  quotient or remainder per op
valid_o  out  1  one-cycle result strobe
div_by_zero_o  out  1  qualifies result_o when valid_o
core_dividend_o  out  DATA_WIDTH  magnitude to core
core_divisor_o  out  DATA_WIDTH  magnitude to core
core_valid_o  out  1  one-cycle core start
core_quotient_i  in  DATA_WIDTH  core quotient
core_remainder_i  in  DATA_WIDTH  core remainder
core_valid_i  in  1  core done strobe

Behaviour:
- Reset: state IDLE; ready_o=1; valid_o=0; core_valid_o=0; div_by_zero_o=0; result_o=0; all operand registers cleared.
- signed = (op==DIV || op==REM). For signed ops, magA = |dividend| and magB = |divisor|; unsigned ops pass operands through. |most-negative| = 0x80..0, which is handled as an unsigned value.
- Sign flags are latched on accept: negQ = signed & (a[msb]^b[msb]); negR = signed & a[msb].
- FSM states: IDLE, LAUNCH, WAIT, DRAIN, DONE.
- IDLE, on accept, the special cases are checked in priority order:
  - divisor==0: Q=all-ones, R=dividend, div_by_zero_o=1, go to DONE.
  - signed, dividend=0x80..0 and divisor=all-ones: Q=dividend, R=0, go to DONE.
  - magA<magB (unsigned compare): Q=0, R=dividend, go to DONE.
  - otherwise: register magA/magB, go to LAUNCH.
- LAUNCH: core_valid_o=1 for exactly one cycle; core_dividend_o/core_divisor_o are stable from LAUNCH through WAIT; next state WAIT.
- WAIT, on core_valid_i:
  - result = (Q-op ? core_quotient_i : core_remainder_i), two's-complement negated when negQ (Q-op) or negR (R-op); negation wraps modulo 2^DATA_WIDTH.
  - Result is registered into result_o; go to DONE.
- DONE: valid_o=1 for one cycle, result_o held until the next accept; next state IDLE.
- Latency:
  - special case: valid_o in the cycle after accept.
  - normal: accept -> LAUNCH (1) -> core latency -> DONE (1). With a core latency of DATA_WIDTH+2, valid_o arrives DATA_WIDTH+4 cycles after accept.
- flush_i, by state:
  - LAUNCH: go to DRAIN, with core_valid_o still pulsed for consistency.
  - WAIT: go to DRAIN.
  - DONE: suppresses valid_o and returns to IDLE.
  - IDLE: no effect.
- DRAIN: ready_o=0; wait for core_valid_i and discard it; then IDLE. No valid_o is issued.
- Simultaneous flush_i and core_valid_i in WAIT: the result is discarded and the next state is IDLE.
- Reset mid-operation: returns immediately to the reset values. The core is reset by the same rst_i, so no drain is needed.
- valid_i while ready_o=0 is ignored; the requester must hold it.
- clk_en_i low freezes the FSM and outputs; valid_o stays high across stalled DONE cycles.

Decomposition:
- Package div_pkg holds div_op_t, the fsm state enum, and a helper function for two's-complement abs/negate parameterised by width.
- One natural sub-module, div_operand_conditioner (combinational): computes magnitudes, sign flags and the special-case select.
- The FSM and result registers stay in the top. The core is instantiated by the parent, not here.

Test Plan:
- DIV -7/2 and REM -7%2 (behavioural core model, latency 34) -> result_o 0xFFFFFFFD and 0xFFFFFFFF respectively; valid_o 36 cycles after accept.
- DIVU 0x80000000/0 -> 0xFFFFFFFF with div_by_zero_o=1 one cycle after accept; REMU same operands -> 0x80000000; core_valid_o never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; no core launch.
- REMU 5/9 -> 5 and DIVU 5/9 -> 0 via fast path; DIV 6/-3 -> 0xFFFFFFFE through the core.
- flush_i in WAIT at cycle 10 -> no valid_o; ready_o stays low until core_valid_i, then a new DIV 100/7 -> 14.
- rst_i pulsed mid-WAIT -> ready_o=1 and valid_o=0 immediately (asynchronous); a following REM 100/7 -> 2.
